// File: rtl/acc_pkg.sv
// Shared types and constants for the frame accumulator.
// Latency: none (declarations only).
// Backpressure: not applicable.
package acc_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Largest positive two's complement value at width w, LSB-aligned.
    function automatic logic [63:0] sat_max_f(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative two's complement value at width w, LSB-aligned.
    function automatic logic [63:0] sat_min_f(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/RippleAdder.sv
// Ripple-carry adder with signed-overflow indication.
// Latency: combinational.
// Backpressure: not applicable.
module RippleAdder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum,
    output logic             overflow
);

    logic [WIDTH:0] c;

    assign c[0] = carry_in;

    // One full adder per bit, carry ripples from bit 0 upward.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    // Signed overflow: carry into the sign bit differs from carry out of it.
    assign overflow = c[WIDTH] ^ c[WIDTH - 1];

endmodule

// File: rtl/frame_accumulator.sv
// Folds a framed stream of signed operands into a running sum; wraps or saturates.
// Latency: 1 cycle per operand; result valid from the edge that takes the last operand.
// Backpressure: in_ready drops while a result waits in HOLD; handoff edge accepts no operand.
module frame_accumulator
    import acc_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int SATURATE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_overflow
);

    localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max_f(WIDTH));
    localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min_f(WIDTH));

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flag_q, flag_d;
    logic [WIDTH-1:0] osum_q, osum_d;
    logic [CNT_W-1:0] ocnt_q, ocnt_d;
    logic             oovf_q, oovf_d;
    // Held low through reset so in_ready only rises after the first clock edge.
    logic             rdy_en_q;

    logic [WIDTH-1:0] add_sum;
    logic             add_ovf;
    logic [WIDTH-1:0] acc_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             flag_nxt;
    logic             xfer;
    logic             handoff;

    RippleAdder #(.WIDTH(WIDTH)) u_add (
        .a        (acc_q),
        .b        (in_data),
        .carry_in (1'b0),
        .sum      (add_sum),
        .overflow (add_ovf)
    );

    // Handshake qualifiers depend only on registered state, never on out_ready.
    assign in_ready  = rdy_en_q & (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign xfer      = in_valid & in_ready;
    assign handoff   = out_valid & out_ready;

    assign out_sum      = osum_q;
    assign out_count    = ocnt_q;
    assign out_overflow = oovf_q;

    // Post-add values: clamp toward the operand's sign on overflow when saturating.
    always_comb begin
        acc_nxt = add_sum;
        if (add_ovf && (SATURATE != 0)) begin
            acc_nxt = in_data[WIDTH-1] ? SAT_MIN : SAT_MAX;
        end
        cnt_nxt  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
        flag_nxt = flag_q | add_ovf;
    end

    // Next-state: clear beats everything, then operand transfer, then result handoff.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        flag_d  = flag_q;
        osum_d  = osum_q;
        ocnt_d  = ocnt_q;
        oovf_d  = oovf_q;
        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            flag_d  = 1'b0;
            osum_d  = '0;
            ocnt_d  = '0;
            oovf_d  = 1'b0;
        end else if (xfer) begin
            acc_d  = acc_nxt;
            cnt_d  = cnt_nxt;
            flag_d = flag_nxt;
            if (in_last) begin
                state_d = HOLD;
                osum_d  = acc_nxt;
                ocnt_d  = cnt_nxt;
                oovf_d  = flag_nxt;
            end
        end else if (handoff) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            flag_d  = 1'b0;
        end
    end

    // State and result registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            flag_q   <= 1'b0;
            osum_q   <= '0;
            ocnt_q   <= '0;
            oovf_q   <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            flag_q   <= flag_d;
            osum_q   <= osum_d;
            ocnt_q   <= ocnt_d;
            oovf_q   <= oovf_d;
            rdy_en_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_frame_accumulator.sv
// Directed bench: saturating and wrapping instances driven by the same stimulus.
// Latency: checks sampled 1 ns after each rising edge.
// Backpressure: exercised via out_ready held low in HOLD.
module tb_frame_accumulator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_ready;

    logic       in_ready,  out_valid,  out_overflow;
    logic [7:0] out_sum,   out_count;
    logic       in_ready_w, out_valid_w, out_overflow_w;
    logic [7:0] out_sum_w,  out_count_w;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    frame_accumulator #(.WIDTH(8), .CNT_W(8), .SATURATE(1)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_count(out_count), .out_overflow(out_overflow)
    );

    frame_accumulator #(.WIDTH(8), .CNT_W(8), .SATURATE(0)) dut_w (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready_w), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid_w), .out_ready(out_ready), .out_sum(out_sum_w),
        .out_count(out_count_w), .out_overflow(out_overflow_w)
    );

    typedef struct {
        logic       vld;
        logic [7:0] dat;
        logic       last;
        logic       ordy;
        logic       clr;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_sum;
        logic [7:0] e_cnt;
        logic       e_ovf;
        logic [7:0] e_sum_w;
        logic       e_ovf_w;
    } vec_t;

    vec_t tbl[12];

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic l,
                                input logic ir, input logic ov, input logic [7:0] s,
                                input logic [7:0] c, input logic f,
                                input logic [7:0] sw, input logic fw);
        vec_t r;
        r.vld = v; r.dat = d; r.last = l; r.ordy = 1'b1; r.clr = 1'b0;
        r.e_ir = ir; r.e_ov = ov; r.e_sum = s; r.e_cnt = c; r.e_ovf = f;
        r.e_sum_w = sw; r.e_ovf_w = fw;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic l,
                         input logic r, input logic c);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
        clear     = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string nm, input logic ir, input logic ov,
                           input logic [7:0] s, input logic [7:0] c, input logic f);
        chk({nm, ".in_ready"},  32'(in_ready),     32'(ir));
        chk({nm, ".out_valid"}, 32'(out_valid),    32'(ov));
        chk({nm, ".out_sum"},   32'(out_sum),      32'(s));
        chk({nm, ".out_count"}, 32'(out_count),    32'(c));
        chk({nm, ".out_ovf"},   32'(out_overflow), 32'(f));
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0;
        in_last = 1'b0; out_ready = 1'b0;

        // 3+5-2; 100+50 (sat 7F / wrap 96); -100-50 (sat 80 / wrap 6A); 1 clears sticky.
        tbl[0]  = mk(1, 8'd3,    0, 1, 0, 8'h00, 8'd0, 0, 8'h00, 0);
        tbl[1]  = mk(1, 8'd5,    0, 1, 0, 8'h00, 8'd0, 0, 8'h00, 0);
        tbl[2]  = mk(1, 8'hFE,   1, 0, 1, 8'h06, 8'd3, 0, 8'h06, 0);
        tbl[3]  = mk(0, 8'h00,   0, 1, 0, 8'h06, 8'd3, 0, 8'h06, 0);
        tbl[4]  = mk(1, 8'd100,  0, 1, 0, 8'h06, 8'd3, 0, 8'h06, 0);
        tbl[5]  = mk(1, 8'd50,   1, 0, 1, 8'h7F, 8'd2, 1, 8'h96, 1);
        tbl[6]  = mk(0, 8'h00,   0, 1, 0, 8'h7F, 8'd2, 1, 8'h96, 1);
        tbl[7]  = mk(1, 8'h9C,   0, 1, 0, 8'h7F, 8'd2, 1, 8'h96, 1);
        tbl[8]  = mk(1, 8'hCE,   1, 0, 1, 8'h80, 8'd2, 1, 8'h6A, 1);
        tbl[9]  = mk(0, 8'h00,   0, 1, 0, 8'h80, 8'd2, 1, 8'h6A, 1);
        tbl[10] = mk(1, 8'd1,    1, 0, 1, 8'h01, 8'd1, 0, 8'h01, 0);
        tbl[11] = mk(0, 8'h00,   0, 1, 0, 8'h01, 8'd1, 0, 8'h01, 0);

        // Reset state, observed while rst_n is low.
        #12;
        chk_out("reset", 0, 0, 8'h00, 8'd0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_release.in_ready", 32'(in_ready), 32'd1);

        foreach (tbl[i]) begin
            drive(tbl[i].vld, tbl[i].dat, tbl[i].last, tbl[i].ordy, tbl[i].clr);
            chk_out($sformatf("vec%0d", i), tbl[i].e_ir, tbl[i].e_ov,
                    tbl[i].e_sum, tbl[i].e_cnt, tbl[i].e_ovf);
            chk($sformatf("vec%0d.wrap_sum", i), 32'(out_sum_w), 32'(tbl[i].e_sum_w));
            chk($sformatf("vec%0d.wrap_ovf", i), 32'(out_overflow_w), 32'(tbl[i].e_ovf_w));
            chk($sformatf("vec%0d.wrap_cnt", i), 32'(out_count_w), 32'(tbl[i].e_cnt));
            chk($sformatf("vec%0d.wrap_vld", i), 32'(out_valid_w), 32'(tbl[i].e_ov));
            chk($sformatf("vec%0d.wrap_rdy", i), 32'(in_ready_w), 32'(tbl[i].e_ir));
        end

        // Backpressure: result 4 held for 5 cycles while 9 is offered.
        drive(1, 8'd4, 1, 0, 0);
        chk_out("bp_enter", 0, 1, 8'd4, 8'd1, 0);
        for (int k = 0; k < 5; k++) begin
            drive(1, 8'd9, 0, 0, 0);
            chk_out($sformatf("bp_hold%0d", k), 0, 1, 8'd4, 8'd1, 0);
        end
        drive(1, 8'd9, 0, 1, 0);
        chk_out("bp_handoff", 1, 0, 8'd4, 8'd1, 0);
        drive(1, 8'd9, 1, 1, 0);
        chk_out("bp_new_frame", 0, 1, 8'd9, 8'd1, 0);
        drive(0, 8'd0, 0, 1, 0);

        // Clear mid-frame drops the same-cycle operand and zeroes outputs.
        drive(1, 8'd10, 0, 1, 0);
        drive(1, 8'd20, 0, 1, 0);
        drive(1, 8'd30, 0, 1, 1);
        chk_out("clear_mid", 1, 0, 8'd0, 8'd0, 0);
        drive(1, 8'd7, 1, 1, 0);
        chk_out("after_clear", 0, 1, 8'd7, 8'd1, 0);
        drive(0, 8'd0, 0, 1, 0);

        // Clear in HOLD discards the pending result.
        drive(1, 8'd5, 1, 0, 0);
        chk_out("hold_for_clear", 0, 1, 8'd5, 8'd1, 0);
        drive(0, 8'd0, 0, 0, 1);
        chk_out("clear_hold", 1, 0, 8'd0, 8'd0, 0);

        // Count saturates at 255 across a 300-operand frame.
        for (int k = 0; k < 299; k++) drive(1, 8'd0, 0, 1, 0);
        drive(1, 8'd0, 1, 1, 0);
        chk_out("count_sat", 0, 1, 8'd0, 8'd255, 0);
        chk("count_sat.wrap_cnt", 32'(out_count_w), 32'd255);
        drive(0, 8'd0, 0, 1, 0);

        // Asynchronous reset mid-HOLD, between edges.
        drive(1, 8'd11, 1, 0, 0);
        chk_out("hold_for_reset", 0, 1, 8'd11, 8'd1, 0);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_out("async_reset", 0, 0, 8'd0, 8'd0, 0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset.in_ready", 32'(in_ready), 32'd1);
        drive(1, 8'd2, 1, 1, 0);
        chk_out("post_reset_frame", 0, 1, 8'd2, 8'd1, 0);
        drive(0, 8'd0, 0, 1, 0);
        chk("post_reset_handoff", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
